// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: fetches a word at PC, holds it in IR until consumed,
// then computes the next PC (jump, taken branch or sequential). Sticky timeout fault.
module if_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    if_stage_if.master       imem,
    output logic [31:0]      instr,
    output logic [5:0]       op_code,
    output logic             instr_valid,
    input  logic             advance,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             imem_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ir;
    logic [31:0] w_ir_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_armed;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_pc_target;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

    always_comb begin
        w_pc_target = w_pc_plus4;
        if (Jump) begin
            w_pc_target = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
        end else if (Branch && Zero) begin
            w_pc_target = w_pc_plus4 + w_br_off;
        end
    end

    // r_armed delays leaving IDLE so the first request lands on the second edge after reset release.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (r_armed) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    w_ir_nxt    = imem.imem_rdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (advance) begin
                    w_pc_nxt    = w_pc_target;
                    w_state_nxt = FETCH;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= 1'b1;
        end
    end

    assign imem.imem_req  = (r_state == FETCH);
    assign imem.imem_addr = r_pc;
    assign instr          = r_ir;
    assign op_code        = r_ir[31:26];
    assign instr_valid    = (r_state == HOLD);
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign imem_err       = (r_state == ERR);

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, number of FETCH cycles without imem_ack before fault (range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  byte address of requested word (= PC).
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  instruction register (IR) contents.
REQ-009 op_code  output  6  instr[31:26], feeds main control decoder.
REQ-010 instr_valid  output  1  IR holds an unconsumed instruction.
REQ-011 advance  input  1  downstream done with IR; compute next PC.
REQ-012 Branch  input  1  control: conditional branch (beq).
REQ-013 Jump  input  1  control: unconditional jump.
REQ-014 Zero  input  1  ALU zero flag for branch decision.
REQ-015 pc  output  32  current PC.
REQ-016 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-017 imem_err  output  1  sticky fetch-timeout fault.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, ERR; encoding free.
REQ-019 IDLE SHALL last exactly one cycle, then go to FETCH; imem_req=0.
REQ-020 FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack sampled high.
REQ-021 FETCH with imem_ack=1 at clock edge: IR<=imem_rdata, timeout counter<=0, go HOLD; ack in the first FETCH cycle is legal (1-cycle fetch).
REQ-022 FETCH with imem_ack=0: counter increments; when counter reaches TIMEOUT-1 without ack, go ERR and set imem_err.
REQ-023 HOLD: instr_valid=1, imem_req=0; IR and pc SHALL not change until advance sampled high.
REQ-024 HOLD with advance=1: pc updates per REQ-025..027, go FETCH; instr_valid drops next cycle.
REQ-025 Jump=1: next pc = {pc_plus4[31:28], instr[25:0], 2'b00}; Jump has priority over Branch.
REQ-026 Branch=1 and Zero=1 (Jump=0): next pc = pc_plus4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-027 Otherwise: next pc = pc_plus4; 0xFFFFFFFC SHALL wrap to 0x00000000.
REQ-028 imem_ack outside FETCH and advance outside HOLD SHALL be ignored.
REQ-029 ERR: imem_req=0, instr_valid=0, imem_err=1; left only by reset.
REQ-030 op_code, pc_plus4 SHALL be combinational from IR and pc; all other outputs registered or decoded from state.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, pc=0x00000000, IR=0x00000000, counter=0, imem_req=0, instr_valid=0, imem_err=0.
REQ-032 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the fetch; a late imem_ack after release is ignored unless state is FETCH.
REQ-033 After rst_n rises, first imem_req SHALL appear on the second rising edge (IDLE then FETCH).

Verification
REQ-034 Reset release, ack on first FETCH cycle with rdata 0x8C220004 -> imem_addr=0x0, instr=0x8C220004, op_code=6'b100011, instr_valid=1 next cycle.
REQ-035 HOLD at pc=0x10, advance with Branch=1, Zero=1, imm=0xFFFE -> next imem_addr=0x0C; with Zero=0 -> 0x14.
REQ-036 pc=0x40000010, instr=0x08000100, Jump=1 and Branch=1, advance -> next imem_addr=0x40000400.
REQ-037 pc=0xFFFFFFFC, no branch/jump, advance -> next imem_addr=0x00000000.
REQ-038 TIMEOUT=16, no ack for 16 FETCH cycles -> imem_err=1, imem_req=0, stays until rst_n low clears it to 0.
REQ-039 advance held high in FETCH and ack held high in HOLD -> pc/IR unchanged until legal state reached.
